// File: rtl/cycle_sequencer.sv
// Instruction-cycle sequencer: drives an external 3-bit step counter and the one-hot timing bus.
// Optional single-step/PAUSE support is compiled in with `define SINGLE_STEP_EN.
module cycle_sequencer #(
  parameter int unsigned MAX_STEP = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       halt_req,
  input  logic       end_instr,
  input  logic       step_mode,
  input  logic       step_go,
  input  logic [2:0] q,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic [7:0] t,
  output logic [1:0] state,
  output logic       running
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    HALT  = 2'b11
  } state_e;

  localparam logic [2:0] LAST_STEP = 3'(MAX_STEP);

  state_e state_q;
  logic   boundary;

  // >= rather than == so a stray out-of-range count is still cleared instead of wrapping
  assign boundary = (state_q == RUN) && (end_instr || (q >= LAST_STEP));
  assign state    = state_q;

`ifndef SINGLE_STEP_EN
  logic unused_step;
  assign unused_step = step_mode ^ step_go;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) state_q <= RUN;
        end
        RUN: begin
          if (boundary) begin
            if (halt_req) begin
              state_q <= HALT;
`ifdef SINGLE_STEP_EN
            end else if (step_mode) begin
              state_q <= PAUSE;
`endif
            end else begin
              state_q <= RUN;
            end
          end
        end
        PAUSE: begin
`ifdef SINGLE_STEP_EN
          if (halt_req) state_q <= HALT;
          else if (step_go) state_q <= RUN;
`else
          // unreachable in this build; fall back to a clean idle state
          state_q <= IDLE;
`endif
        end
        HALT: begin
          if (start && !halt_req) state_q <= RUN;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_en  = 1'b1;
    cnt_clr = 1'b1;
    t       = '0;
    running = 1'b0;
    case (state_q)
      RUN: begin
        cnt_clr = boundary;
        t       = 8'(1) << q;
        running = 1'b1;
      end
      PAUSE: begin
        cnt_en  = 1'b0;
        cnt_clr = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed bench for cycle_sequencer with a behavioural model of the external step counter.
module tb_cycle_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, halt_req = 1'b0, end_instr = 1'b0, step_mode = 1'b0, step_go = 1'b0;
  logic [2:0] q = '0;
  logic cnt_en, cnt_clr, running;
  logic [7:0] t;
  logic [1:0] state;

  logic start3 = 1'b0;
  logic [2:0] q3 = '0;
  logic cnt_en3, cnt_clr3, running3;
  logic [7:0] t3;
  logic [1:0] state3;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cycle_sequencer #(.MAX_STEP(7)) dut (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req), .end_instr(end_instr),
    .step_mode(step_mode), .step_go(step_go), .q(q), .cnt_en(cnt_en), .cnt_clr(cnt_clr),
    .t(t), .state(state), .running(running)
  );

  cycle_sequencer #(.MAX_STEP(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .halt_req(1'b0), .end_instr(1'b0),
    .step_mode(1'b0), .step_go(1'b0), .q(q3), .cnt_en(cnt_en3), .cnt_clr(cnt_clr3),
    .t(t3), .state(state3), .running(running3)
  );

  // external step counters
  always @(posedge clk) begin
    if (cnt_en) q <= cnt_clr ? 3'd0 : q + 3'd1;
    if (cnt_en3) q3 <= cnt_clr3 ? 3'd0 : q3 + 3'd1;
  end

  typedef struct {
    logic st, hr, ei, sm, sg;
    logic [1:0] es;
    logic [2:0] eq;
    logic [7:0] et;
    logic een, eclr;
  } vec_t;

  vec_t tbl[23];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic hr, input logic ei, input logic sm, input logic sg);
    start = st; halt_req = hr; end_instr = ei; step_mode = sm; step_go = sg;
    #1;
  endtask

  task automatic chk_all(input string nm, input logic [1:0] es, input logic [2:0] eq,
                         input logic [7:0] et, input logic een, input logic eclr);
    chk({nm, " state"}, int'(state), int'(es));
    chk({nm, " q"}, int'(q), int'(eq));
    chk({nm, " t"}, int'(t), int'(et));
    chk({nm, " cnt_en"}, int'(cnt_en), int'(een));
    chk({nm, " cnt_clr"}, int'(cnt_clr), int'(eclr));
    chk({nm, " running"}, int'(running), (es == 2'b01) ? 1 : 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //              st    hr    ei    sm    sg    state  q     t      en    clr
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'd0, 8'h00, 1'b1, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'd0, 8'h00, 1'b1, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'd0, 8'h01, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'd1, 8'h02, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'd2, 8'h04, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'd3, 8'h08, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'd4, 8'h10, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'd5, 8'h20, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'd6, 8'h40, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'd7, 8'h80, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'd0, 8'h01, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 3'd1, 8'h02, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 3'd2, 8'h04, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 3'd3, 8'h08, 1'b1, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'd0, 8'h01, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'd1, 8'h02, 1'b1, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 3'd2, 8'h04, 1'b1, 1'b0};
    tbl[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 3'd3, 8'h08, 1'b1, 1'b0};
    tbl[18] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 3'd4, 8'h10, 1'b1, 1'b1};
    tbl[19] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 3'd0, 8'h00, 1'b1, 1'b1};
    tbl[20] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 3'd0, 8'h00, 1'b1, 1'b1};
    tbl[21] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 3'd0, 8'h01, 1'b1, 1'b1};
    tbl[22] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'd0, 8'h01, 1'b1, 1'b0};

    // reset, then release away from a clock edge
    #22 rst = 1'b1;
    tick();

    // MAX_STEP=3 instance: counter must clear at 3 without end_instr
    start3 = 1'b1;
    #1;
    chk("m3 idle state", int'(state3), 0);
    tick();
    start3 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("m3 c%0d q", k), int'(q3), k % 4);
      chk($sformatf("m3 c%0d t", k), int'(t3), 1 << (k % 4));
      chk($sformatf("m3 c%0d clr", k), int'(cnt_clr3), ((k % 4) == 3) ? 1 : 0);
      chk($sformatf("m3 c%0d running", k), int'(running3), 1);
      tick();
    end

    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].st, tbl[i].hr, tbl[i].ei, tbl[i].sm, tbl[i].sg);
      chk_all($sformatf("v%0d", i), tbl[i].es, tbl[i].eq, tbl[i].et, tbl[i].een, tbl[i].eclr);
      tick();
    end

    // instruction ending at q=5 with step_mode requested at the boundary
    for (int k = 1; k < 5; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_all($sformatf("sm q%0d", k), 2'b01, 3'(k), 8'(1 << k), 1'b1, 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk_all("sm boundary", 2'b01, 3'd5, 8'h20, 1'b1, 1'b1);
    tick();

`ifdef SINGLE_STEP_EN
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk_all($sformatf("pause%0d", k), 2'b10, 3'd0, 8'h00, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk_all("pause go", 2'b10, 3'd0, 8'h00, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk_all($sformatf("step q%0d", k), 2'b01, 3'(k), 8'(1 << k), 1'b1, (k == 7) ? 1'b1 : 1'b0);
      tick();
    end
    // step_go held: PAUSE and one-step RUN must alternate
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      chk($sformatf("held go %0d state", k), int'(state), (k % 2 == 0) ? 2 : 1);
      tick();
    end
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("pause halt prio pre", int'(state), 2);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_all("pause halt prio", 2'b11, 3'd0, 8'h00, 1'b1, 1'b1);
    tick();
`else
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk_all("no pause", 2'b01, 3'd0, 8'h01, 1'b1, 1'b0);
    tick();
`endif

    // get back to RUN from a clean instruction start
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("to halt clr", int'(cnt_clr), 1);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("to halt state", int'(state), 3);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("pre rst q%0d", k), int'(q), k);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_all("pre rst q4", 2'b01, 3'd4, 8'h10, 1'b1, 1'b0);

    // asynchronous reset between edges
    #1 rst = 1'b0;
    #1;
    chk("async rst state", int'(state), 0);
    chk("async rst t", int'(t), 0);
    chk("async rst running", int'(running), 0);
    chk("async rst en", int'(cnt_en), 1);
    chk("async rst clr", int'(cnt_clr), 1);
    chk("async rst m3 state", int'(state3), 0);
    tick();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_all("post rst", 2'b00, 3'd0, 8'h00, 1'b1, 1'b1);
    tick();
    chk_all("post rst edge", 2'b00, 3'd0, 8'h00, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
